// File: rtl/return_stack.sv
// Call/return address stack: circular register array with count, full/empty and sticky error flags.
// Define RET_STACK_WRAP_EN to let a push while full overwrite the oldest entry instead of being dropped.
module return_stack #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12
) (
  input  logic                       clock,
  input  logic                       init_signal,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          pushAddress,
  input  logic                       clearErrors,
  output logic [ADDR_W-1:0]          topAddress,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  top_idx;
  logic              is_empty, is_full;

  assign top_idx  = sp_q - PTR_W'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    overflow_d  = clearErrors ? 1'b0 : overflow_q;
    underflow_d = clearErrors ? 1'b0 : underflow_q;
    wr_en       = 1'b0;
    wr_idx      = sp_q;

    if (push && pop && !is_empty) begin
      // Return immediately followed by a call: replace the top in place.
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      if (!is_full) begin
        wr_en   = 1'b1;
        sp_d    = sp_q + PTR_W'(1);
        count_d = count_q + CNT_W'(1);
      end else begin
        overflow_d = 1'b1;
`ifdef RET_STACK_WRAP_EN
        wr_en = 1'b1;
        sp_d  = sp_q + PTR_W'(1);
`endif
      end
    end else if (pop) begin
      if (!is_empty) begin
        sp_d    = sp_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!init_signal) begin
      sp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (init_signal && wr_en) begin
      mem_q[wr_idx] <= pushAddress;
    end
  end

  assign topAddress = is_empty ? '0 : mem_q[top_idx];
  assign count      = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_return_stack;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              init_signal, push, pop, clearErrors;
  logic [ADDR_W-1:0] pushAddress;
  logic [ADDR_W-1:0] topAddress;
  logic [3:0]        count;
  logic              empty, full, overflow, underflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    bit          chk;
    logic [11:0] top;
    int          cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];
  int   step_id = 0;

  return_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock       (clock),
    .init_signal (init_signal),
    .push        (push),
    .pop         (pop),
    .pushAddress (pushAddress),
    .clearErrors (clearErrors),
    .topAddress  (topAddress),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  task automatic cmp(input int id, input string what, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL step=%0d %s actual=0x%0h required=0x%0h", id, what, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, after the inputs for that cycle were applied.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        cmp(e.id, "top", int'(topAddress), int'(e.top));
        cmp(e.id, "count", int'(count), e.cnt);
        cmp(e.id, "empty", int'(empty), int'(e.cnt == 0));
        cmp(e.id, "full", int'(full), int'(e.cnt == DEPTH));
        cmp(e.id, "overflow", int'(overflow), int'(e.ovf));
        cmp(e.id, "underflow", int'(underflow), int'(e.unf));
        $display("step %0d: top=0x%03h count=%0d empty=%0b full=%0b ovf=%0b unf=%0b",
                 e.id, topAddress, count, empty, full, overflow, underflow);
      end
    end
  end

  // Apply one cycle of inputs and queue what the outputs must show during that cycle.
  task automatic step(input logic rst_n, input logic ps, input logic pp, input logic [11:0] addr,
                      input logic clr, input bit chk, input logic [11:0] e_top, input int e_cnt,
                      input logic e_ovf, input logic e_unf);
    exp_t e;
    @(posedge clock);
    #1;
    init_signal = rst_n;
    push        = ps;
    pop         = pp;
    pushAddress = addr;
    clearErrors = clr;
    step_id++;
    e.id  = step_id;
    e.chk = chk;
    e.top = e_top;
    e.cnt = e_cnt;
    e.ovf = e_ovf;
    e.unf = e_unf;
    exp_q.push_back(e);
  endtask

  initial begin
    init_signal = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    pushAddress = '0;
    clearErrors = 1'b0;

    // Reset held two cycles with push asserted
    step(0, 1, 0, 12'h5A5, 0, 0, 12'h000, 0, 0, 0);
    step(0, 1, 0, 12'h5A5, 0, 1, 12'h000, 0, 0, 0);
    step(1, 0, 0, 12'h000, 0, 1, 12'h000, 0, 0, 0);

    // LIFO order
    step(1, 1, 0, 12'h010, 0, 1, 12'h000, 0, 0, 0);
    step(1, 1, 0, 12'h020, 0, 1, 12'h010, 1, 0, 0);
    step(1, 1, 0, 12'h030, 0, 1, 12'h020, 2, 0, 0);
    step(1, 0, 1, 12'h000, 0, 1, 12'h030, 3, 0, 0);
    step(1, 0, 1, 12'h000, 0, 1, 12'h020, 2, 0, 0);
    step(1, 0, 1, 12'h000, 0, 1, 12'h010, 1, 0, 0);
    step(1, 0, 0, 12'h000, 0, 1, 12'h000, 0, 0, 0);

    // Underflow, clear, and set-wins-over-clear
    step(1, 0, 1, 12'h000, 0, 1, 12'h000, 0, 0, 0);
    step(1, 0, 0, 12'h000, 1, 1, 12'h000, 0, 0, 1);
    step(1, 0, 1, 12'h000, 1, 1, 12'h000, 0, 0, 0);
    step(1, 0, 0, 12'h000, 0, 1, 12'h000, 0, 0, 1);
    step(1, 0, 0, 12'h000, 1, 1, 12'h000, 0, 0, 1);
    step(1, 0, 0, 12'h000, 0, 1, 12'h000, 0, 0, 0);

    // Push+pop while empty acts as a push, no underflow
    step(1, 1, 1, 12'h070, 0, 1, 12'h000, 0, 0, 0);
    step(1, 0, 1, 12'h000, 0, 1, 12'h070, 1, 0, 0);
    step(1, 0, 0, 12'h000, 0, 1, 12'h000, 0, 0, 0);

    // Push+pop with two entries replaces the top
    step(1, 1, 0, 12'h040, 0, 1, 12'h000, 0, 0, 0);
    step(1, 1, 0, 12'h050, 0, 1, 12'h040, 1, 0, 0);
    step(1, 1, 1, 12'h060, 0, 1, 12'h050, 2, 0, 0);
    step(1, 0, 1, 12'h000, 0, 1, 12'h060, 2, 0, 0);
    step(1, 0, 1, 12'h000, 0, 1, 12'h040, 1, 0, 0);
    step(1, 0, 0, 12'h000, 0, 1, 12'h000, 0, 0, 0);

    // Fill to DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      logic [11:0] a;
      logic [11:0] t;
      a = 12'h100 + 12'(i);
      t = (i == 0) ? 12'h000 : 12'h100 + 12'(i - 1);
      step(1, 1, 0, a, 0, 1, t, i, 0, 0);
    end

`ifdef RET_STACK_WRAP_EN
    step(1, 1, 0, 12'h108, 0, 1, 12'h107, 8, 0, 0);
    step(1, 0, 0, 12'h000, 0, 1, 12'h108, 8, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      logic [11:0] t;
      t = 12'h108 - 12'(i);
      step(1, 0, 1, 12'h000, 0, 1, t, 8 - i, 1, 0);
    end
`else
    step(1, 1, 0, 12'h1FF, 0, 1, 12'h107, 8, 0, 0);
    step(1, 0, 0, 12'h000, 0, 1, 12'h107, 8, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      logic [11:0] t;
      t = 12'h107 - 12'(i);
      step(1, 0, 1, 12'h000, 0, 1, t, 8 - i, 1, 0);
    end
`endif
    step(1, 0, 0, 12'h000, 1, 1, 12'h000, 0, 1, 0);
    step(1, 0, 0, 12'h000, 0, 1, 12'h000, 0, 0, 0);

    // Drain: the monitor must have consumed every queued expectation
    @(negedge clock);
    @(negedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware call/return address stack.
- Responds to the push/pop strobes issued by the processor controller.
  - On a call, it captures the return address.
  - On a return, it supplies the top entry to the PC input mux (mux select 2'b10).
- Sits beside the PC register and PC adder in the datapath.
- Provides full/empty status and sticky error flags.

Parameters:
- DEPTH, 8, number of entries; must be a power of two, 2..64.
- ADDR_W, 12, width of a stored address; matches the instruction address field.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- init_signal  input  1  synchronous, active-low reset.
- push  input  1  store pushAddress as the new top (call).
- pop  input  1  remove the top entry (return).
- pushAddress  input  ADDR_W  return address to store (PC+1).
- clearErrors  input  1  synchronous clear of overflow and underflow.
- topAddress  output  ADDR_W  current top entry; combinational; 0 when empty.
- count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; a push was attempted while full.
- underflow  output  1  sticky; a pop was attempted while empty.

Behaviour:
- Reset: init_signal==0 at a rising edge sets:
  - stack pointer = 0, count = 0;
  - overflow = 0, underflow = 0;
  - hence empty = 1, full = 0, topAddress = 0.
  - Storage array is not reset.
  - Reset overrides push, pop and clearErrors in the same cycle.
- Storage: DEPTH x ADDR_W register array.
  - sp indexes the next free slot; top = entry[sp-1] modulo DEPTH.
- topAddress:
  - Combinational read of the top entry, valid in the same cycle pop is asserted, so the PC loads it at that edge.
  - Forced to 0 when empty.
- Push only (push=1, pop=0):
  - If not full: entry[sp] <= pushAddress, sp <= sp+1, count <= count+1.
  - New top is visible the cycle after the edge.
- Pop only (push=0, pop=1):
  - If not empty: sp <= sp-1, count <= count-1.
  - If empty: no state change except underflow <= 1.
- Simultaneous push and pop:
  - count>0: replace the top, i.e. entry[sp-1] <= pushAddress; sp and count unchanged; no flags change.
  - count==0: treat as push only; underflow is not set.
- Full boundary, push only while full: behaviour depends on RET_STACK_WRAP_EN (see Optional Feature).
- Pointer arithmetic: sp is $clog2(DEPTH) bits and wraps modulo DEPTH. count never exceeds DEPTH and never goes below 0.
- Error flags:
  - clearErrors=1 clears both flags at the edge.
  - If an error event occurs in the same cycle, the set wins (flag ends at 1).
- Latency: one cycle for every state update; zero cycles for the topAddress read.
- No internal FSM beyond pointer and count. The block is a registered circular buffer; a behavioural state view is EMPTY / PARTIAL / FULL, derived from count.

Optional Feature:
- Macro: RET_STACK_WRAP_EN.
- Defined — push while full (pop=0):
  - entry[sp] <= pushAddress, sp <= sp+1, count stays DEPTH, overflow <= 1.
  - The oldest entry is overwritten; the most recent DEPTH addresses remain retrievable in LIFO order.
- Not defined — push while full (pop=0):
  - Push is dropped; storage, sp and count are unchanged; overflow <= 1.
  - topAddress keeps the previous top.

Test Plan:
- Reset: drive init_signal=0 for 2 cycles with push=1 -> count=0, empty=1, full=0, topAddress=0x000, overflow=0, underflow=0.
- LIFO: push 0x010, 0x020, 0x030 on consecutive cycles, then pop three times -> topAddress reads 0x030, 0x020, 0x010 in the pop cycles; count goes 3,2,1,0; empty=1 at end.
- Fill/full, macro undefined: push 0x100..0x107 (8 pushes) -> full=1, count=8. Push 0x1FF -> overflow=1, topAddress stays 0x107. Pop 8 times -> returns 0x107 down to 0x100.
- Fill/full, macro defined: push 0x100..0x108 (9 pushes) -> overflow=1, count=8, topAddress=0x108. Pop 8 times -> returns 0x108 down to 0x101, then empty=1.
- Underflow and clear: pop when empty -> underflow=1, count stays 0. Next cycle clearErrors=1 -> underflow=0. Then clearErrors=1 together with pop on empty -> underflow remains 1.
- Simultaneous push+pop:
  - With stack {0x040, 0x050}: push=pop=1 with pushAddress=0x060 -> count=2, topAddress=0x060; a following pop gives 0x060 then 0x040.
  - When empty: push=pop=1 with 0x070 -> count=1, topAddress=0x070, underflow=0.
